// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative multiply/divide unit holding the architectural HI/LO registers.
//   It executes MULT/MULTU/DIV/DIVU over WIDTH radix-2 steps and services
//   MTHI/MTLO writes while idle. busy feeds the pipeline stall so dependent
//   MFHI/MFLO and new multiply/divide instructions wait for the result.
//
// Ports
//   clk     in   1      rising-edge clock
//   rst_n   in   1      synchronous active-low reset
//   start   in   1      launch an op (accepted only when idle)
//   op      in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   rs_val  in   WIDTH  multiplicand / dividend
//   rt_val  in   WIDTH  multiplier / divisor
//   hi_we   in   1      MTHI write strobe
//   lo_we   in   1      MTLO write strobe
//   wdata   in   WIDTH  MTHI/MTLO write data
//   busy    out  1      op in flight
//   done    out  1      one-cycle pulse when HI/LO were written by an op
//   hi      out  WIDTH  HI register
//   lo      out  WIDTH  LO register
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   opa;
    logic [WIDTH-1:0]   opb;
    logic               neg_a;
    logic               neg_b;
    logic               is_div;
    logic               div_zero;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   rem;

    logic               accept;
    logic               step;
    logic               finish;
    logic               mt_ok;

    logic               rs_neg;
    logic               rt_neg;
    logic [WIDTH-1:0]   rs_mag;
    logic [WIDTH-1:0]   rt_mag;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem_next;
    logic [WIDTH-1:0]   div_q_next;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    // busy is a pure decode of the state register, so it is glitch-free and
    // drops in the same cycle that done rises.
    assign busy = (state != IDLE);

    // State register. Reset wins over everything, which is also how an
    // in-flight op gets aborted without ever reaching FIN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control strobes. RUN lasts exactly WIDTH cycles: it
    // exits on the edge at which cnt becomes WIDTH. MTHI/MTLO are only
    // honoured when idle and no op is being launched, so start always wins.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        mt_ok      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    mt_ok = 1'b1;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == CW'(WIDTH - 1)) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                finish     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand conditioning at launch: signed ops (op[0]==0) iterate on
    // magnitudes and remember the signs; unsigned ops use the raw values.
    always_comb begin
        rs_neg = ~op[0] & rs_val[WIDTH-1];
        rt_neg = ~op[0] & rt_val[WIDTH-1];
        rs_mag = rs_neg ? -rs_val : rs_val;
        rt_mag = rt_neg ? -rt_val : rt_val;
    end

    // One radix-2 iteration for each algorithm.
    // Multiply: the low half of acc starts as the multiplier and is consumed
    // LSB first while the product grows into the high half; the extra carry
    // bit of mul_sum shifts down into the top of acc.
    // Divide: restoring division. The low half of acc starts as the dividend
    // and fills with quotient bits from the right; the shifted partial
    // remainder needs WIDTH+1 bits, but after the conditional subtract it is
    // always smaller than the divisor, so WIDTH bits are enough to store it.
    // With a zero divisor the remainder may overflow and is discarded, as
    // the result is overridden at FIN anyway.
    always_comb begin
        mul_sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opa} : '0);
        mul_next     = {mul_sum, acc[WIDTH-1:1]};
        div_shift    = {rem, acc[WIDTH-1]};
        div_ge       = (div_shift >= {1'b0, opb});
        div_rem_next = WIDTH'(div_ge ? (div_shift - {1'b0, opb}) : div_shift);
        div_q_next   = {acc[WIDTH-2:0], div_ge};
    end

    // Final sign correction and result selection. The signed overflow case
    // (most negative / -1) needs no special path: negating the magnitude
    // quotient 2^(WIDTH-1) wraps back onto itself and the remainder is zero.
    // For divide by zero, -|rs| (or |rs| when non-negative) reproduces the
    // dividend exactly as issued.
    always_comb begin
        prod_fix = (neg_a ^ neg_b) ? -acc : acc;
        quot_fix = (neg_a ^ neg_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = neg_a ? -rem : rem;
        res_hi   = prod_fix[2*WIDTH-1:WIDTH];
        res_lo   = prod_fix[WIDTH-1:0];
        if (is_div) begin
            if (div_zero) begin
                res_lo = '1;
                res_hi = neg_a ? -opa : opa;
            end else begin
                res_lo = quot_fix;
                res_hi = rem_fix;
            end
        end
    end

    // Datapath and architectural registers. Operands are captured only on
    // accept, so a start pulse during RUN/FIN has no effect. HI/LO change
    // only on reset, at FIN, or on an accepted MTHI/MTLO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            cnt      <= '0;
            opa      <= '0;
            opb      <= '0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            is_div   <= 1'b0;
            div_zero <= 1'b0;
            acc      <= '0;
            rem      <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                opa      <= rs_mag;
                opb      <= rt_mag;
                neg_a    <= rs_neg;
                neg_b    <= rt_neg;
                is_div   <= op[1];
                div_zero <= (rt_val == '0);
                cnt      <= '0;
                rem      <= '0;
                acc      <= {{WIDTH{1'b0}}, (op[1] ? rs_mag : rt_mag)};
            end else if (step) begin
                cnt <= cnt + CW'(1);
                if (is_div) begin
                    rem              <= div_rem_next;
                    acc[WIDTH-1:0]   <= div_q_next;
                end else begin
                    acc <= mul_next;
                end
            end else if (finish) begin
                hi   <= res_hi;
                lo   <= res_lo;
                done <= 1'b1;
            end else if (mt_ok) begin
                if (hi_we) begin
                    hi <= wdata;
                end
                if (lo_we) begin
                    lo <= wdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Directed testbench for muldiv_unit: a table of hand-computed operations
//   with latency/busy/done checks, plus hand-written sequences for reset,
//   ignored start/MTHI during an op, start-vs-MTHI priority, reset abort and
//   MTHI/MTLO writes.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

    localparam int WIDTH = 32;
    localparam int LAT   = WIDTH + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int pass_count  = 0;
    int check_count = 0;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    // Free-running 100 MHz-style clock.
    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .hi_we  (hi_we),
        .lo_we  (lo_we),
        .wdata  (wdata),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    // Global watchdog in case the sequencing itself gets stuck.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point; every check goes through here.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Launch one op, track busy until done, then check result and timing.
    // Operands are scrambled right after the accept edge to show they are
    // only sampled on that edge.
    task automatic applyStimulus(input vec_t v);
        int   edges;
        logic busy_held;
        @(negedge clk);
        start  = 1'b1;
        op     = v.op;
        rs_val = v.a;
        rt_val = v.b;
        @(posedge clk);
        #1;
        start  = 1'b0;
        rs_val = $urandom;
        rt_val = $urandom;
        op     = 2'($urandom);
        busy_held = busy;
        edges     = 0;
        while (done !== 1'b1 && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
            if (done !== 1'b1 && busy !== 1'b1) busy_held = 1'b0;
        end
        checkOutput({v.name, " latency"}, 64'(edges), 64'(LAT));
        checkOutput({v.name, " busy held"}, 64'(busy_held), 64'(1));
        checkOutput({v.name, " busy at done"}, 64'(busy), 64'(0));
        checkOutput({v.name, " hi"}, 64'(hi), 64'(v.exp_hi));
        checkOutput({v.name, " lo"}, 64'(lo), 64'(v.exp_lo));
        @(posedge clk);
        #1;
        checkOutput({v.name, " done one cycle"}, 64'(done), 64'(0));
    endtask

    // Wait for done with a bounded number of edges, counting edges elapsed.
    task automatic waitDone(inout int edges);
        while (done !== 1'b1 && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    // Count done pulses and busy cycles over a quiet window.
    task automatic watchIdle(input int cycles, output int done_seen, output int busy_seen);
        done_seen = 0;
        busy_seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) done_seen++;
            if (busy !== 1'b0) busy_seen++;
        end
    endtask

    // Main sequence.
    initial begin
        int edges;
        int done_seen;
        int busy_seen;
        logic [31:0] prev_hi;
        logic [31:0] prev_lo;

        rst_n  = 1'b0;
        start  = 1'b1;
        op     = 2'b01;
        rs_val = 32'hDEADBEEF;
        rt_val = 32'h12345678;
        hi_we  = 1'b1;
        lo_we  = 1'b1;
        wdata  = 32'hFFFF0000;

        vecs[0]  = '{"MULTU max*max",     2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{"MULT -3*7",         2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2]  = '{"MULT min*min",      2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[3]  = '{"DIV -7/2",          2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4]  = '{"DIVU 7/0",          2'b11, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
        vecs[5]  = '{"DIV min/-1",        2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[6]  = '{"MULTU x*16",        2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
        vecs[7]  = '{"MULT 7*-1",         2'b00, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9};
        vecs[8]  = '{"DIV 7/-2",          2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[9]  = '{"DIV -7/0",          2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[10] = '{"DIVU max/16",       2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
        vecs[11] = '{"MULTU 2^31*2",      2'b01, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000};
        vecs[12] = '{"DIVU 100/7",        2'b11, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};

        // Reset held for two edges with start and both write strobes active.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset hi", 64'(hi), 64'(0));
        checkOutput("reset lo", 64'(lo), 64'(0));
        checkOutput("reset busy", 64'(busy), 64'(0));
        checkOutput("reset done", 64'(done), 64'(0));
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
        end

        // Mid-run start and MTHI are both ignored; exactly one done follows.
        $display("[TB] start/MTHI during DIVU 100/7");
        prev_hi = hi;
        @(negedge clk);
        start  = 1'b1;
        op     = 2'b11;
        rs_val = 32'd100;
        rt_val = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        edges = 0;
        repeat (5) begin
            @(posedge clk);
            edges++;
        end
        @(negedge clk);
        start  = 1'b1;
        op     = 2'b01;
        rs_val = 32'd3;
        rt_val = 32'd3;
        hi_we  = 1'b1;
        wdata  = 32'h55;
        @(posedge clk);
        #1;
        edges++;
        start = 1'b0;
        hi_we = 1'b0;
        checkOutput("busy MTHI dropped", 64'(hi), 64'(prev_hi));
        waitDone(edges);
        checkOutput("busy-start latency", 64'(edges), 64'(LAT));
        checkOutput("busy-start lo", 64'(lo), 64'(14));
        checkOutput("busy-start hi", 64'(hi), 64'(2));
        watchIdle(40, done_seen, busy_seen);
        checkOutput("busy-start extra done", 64'(done_seen), 64'(0));
        checkOutput("busy-start no relaunch", 64'(busy_seen), 64'(0));

        // start and MTHI/MTLO in the same idle cycle: start wins.
        $display("[TB] start vs MTHI/MTLO priority");
        prev_hi = hi;
        prev_lo = lo;
        @(negedge clk);
        start  = 1'b1;
        op     = 2'b01;
        rs_val = 32'd2;
        rt_val = 32'd3;
        hi_we  = 1'b1;
        lo_we  = 1'b1;
        wdata  = 32'hAAAA;
        @(posedge clk);
        #1;
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        checkOutput("priority hi held", 64'(hi), 64'(prev_hi));
        checkOutput("priority lo held", 64'(lo), 64'(prev_lo));
        checkOutput("priority op launched", 64'(busy), 64'(1));
        edges = 0;
        waitDone(edges);
        checkOutput("priority hi", 64'(hi), 64'(0));
        checkOutput("priority lo", 64'(lo), 64'(6));

        // Reset at cnt=10 of a DIV aborts the op with no done pulse.
        $display("[TB] reset abort mid-DIV");
        @(negedge clk);
        start  = 1'b1;
        op     = 2'b10;
        rs_val = 32'd100;
        rt_val = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort busy", 64'(busy), 64'(0));
        checkOutput("abort hi", 64'(hi), 64'(0));
        checkOutput("abort lo", 64'(lo), 64'(0));
        checkOutput("abort done", 64'(done), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        watchIdle(40, done_seen, busy_seen);
        checkOutput("abort no done later", 64'(done_seen), 64'(0));

        // MTHI and MTLO together, then MTHI alone.
        $display("[TB] MTHI/MTLO writes");
        @(negedge clk);
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h1234;
        @(posedge clk);
        #1;
        checkOutput("MT both hi", 64'(hi), 64'(32'h1234));
        checkOutput("MT both lo", 64'(lo), 64'(32'h1234));
        @(negedge clk);
        lo_we = 1'b0;
        wdata = 32'h77;
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        checkOutput("MTHI only hi", 64'(hi), 64'(32'h77));
        checkOutput("MTHI only lo", 64'(lo), 64'(32'h1234));
        checkOutput("MT no done", 64'(done), 64'(0));

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
